svn_scan_ctrl: RTL
==================

// Module: svn_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an N_DIG-digit common-anode 7-segment display.
//  Double-buffers a packed hex word from the host and steps through the digits one slot
//  at a time. Each slot has a dead-time blank followed by the lit phase.
//  Drives the nibble into the svn_dcdr decoder and drives the active-low anode enables.
//  Replaces the free-running anode shift ring with a rate-controlled, glitch-free scan.
// PARAMETERS
//  N_DIG   8       number of digits (>=2)
//  DIV     100000  clk cycles per digit slot (>=2)
//  BLANK   16      dead-time cycles at start of each slot, AN all high (0 <= BLANK < DIV)
// PORTS
//  clk       in   1          system clock
//  sys_rst   in   1          synchronous reset, active-high
//  wr_en     in   1          host write request; taken only when wr_ready=1
//  wr_data   in   4*N_DIG    digit nibbles; digit i = wr_data[4i+3:4i]
//  wr_dp     in   N_DIG      decimal-point request per digit, active-high
//  wr_den    in   N_DIG      digit enable per digit; 0 = digit kept dark
//  wr_ready  out  1          1 = pending buffer empty, write accepted this cycle
//  seg_val   out  4          nibble for the current digit, to svn_dcdr.in
//  seg_dp    out  1          dp request for the current digit, active-high
//  AN        out  N_DIG      anode enables, active-low, at most one bit low
//  digit_idx out  clog2(N_DIG)  index of the current slot
//  frame_done out 1          1-cycle pulse on the last cycle of slot N_DIG-1
// BEHAVIOUR
//  Reset values (sys_rst=1 at an edge):
//   - cnt=0, idx=0, state=BLANK
//   - AN all 1; seg_val=0, seg_dp=0; frame_done=0
//   - active buffer: data=0, dp=0, den=0 (display dark)
//   - pending_valid=0, so wr_ready=1 one cycle after reset
//  Prescaler: cnt runs 0..DIV-1 and wraps; tick = (cnt==DIV-1).
//  FSM, 2 states:
//   - BLANK: AN all 1 while cnt<BLANK. BLANK->SHOW when cnt==BLANK-1. With BLANK=0, SHOW is entered directly.
//   - SHOW: AN[idx]=~den[idx], all other AN bits 1. SHOW->BLANK on tick.
//  On tick:
//   - idx <= (idx==N_DIG-1) ? 0 : idx+1.
//   - seg_val and seg_dp are registered from the active buffer of the new idx on that same edge, so they are stable across the whole next slot.
//  Frame end (tick && idx==N_DIG-1):
//   - frame_done=1 that cycle.
//   - If pending_valid: active <= pending and pending_valid <= 0 on the same edge.
//   - seg_val for slot 0 is taken from the newly committed data.
//  Write handshake:
//   - wr_ready = ~pending_valid (combinational from the register).
//   - wr_en && wr_ready: capture wr_data/wr_dp/wr_den into pending; pending_valid <= 1.
//   - wr_en while wr_ready=0 is ignored with no error; the host must hold or retry.
//   - Write and commit in the same cycle: wr_ready is already 0, so the write is dropped. The commit wins.
//  Latency: an accepted write first shows at the slot-0 start of the next frame boundary. The earliest low AN follows after a further BLANK cycles.
//  AN glitch-free: AN is registered, and it never has two bits low on any cycle, including across slot change.
//  Reset mid-slot: everything returns to reset values on the next edge. Pending data is discarded.
//  frame_done period = N_DIG*DIV cycles, exactly.
// STRUCTURE
//  Package svn_pkg:
//   - scan_state_t enum {ST_BLANK, ST_SHOW}
//   - AN_OFF constant (all ones)
//   - function to clog2 the index width
//  Sub-module scan_tick_gen:
//   - DIV/BLANK counter with sync active-high reset
//   - outputs tick and blank_end
//  The top level holds the FSM, the idx counter, the buffers and the output registers.
//  The svn_dcdr instance stays in the enclosing wrapper, not here.
// TESTING (bench params N_DIG=4, DIV=8, BLANK=2)
//  1 Reset 3 cycles -> AN=4'b1111, seg_val=0, frame_done=0, wr_ready=1, digit_idx=0.
//  2 Write 16'h1234, den=4'b1111 -> frame_done pulses every 32 cycles. In slot 0: AN=1111 for 2 cycles, then 1110 for 6 cycles, seg_val=4. Slot 1: seg_val=3, AN=1101.
//  3 Two back-to-back writes (A then B before frame end) -> wr_ready=0 after A, B ignored, display shows A. wr_ready returns to 1 the cycle after commit.
//  4 Write with den=4'b0101 -> AN stays 1111 during slots 1 and 3. AN lows only in slots 0 and 2.
//  5 wr_en asserted exactly on the commit cycle -> that write is dropped. Check wr_ready=0 that cycle.
//  6 sys_rst pulsed mid-SHOW in slot 2 -> the next cycle matches reset values, and the pending write is lost.
//  Always-on assertions:
//   - $onehot0(~AN)
//   - AN==all-ones whenever cnt<BLANK
//   - frame_done width is 1 cycle

Source files
------------

// File: rtl/svn_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package svn_pkg;

    localparam int unsigned MAX_DIG = 64;

    typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;

    // Anode bus with every digit off (active-low enables).
    localparam logic [MAX_DIG-1:0] AN_OFF = '1;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/svn_scan_ctrl_if.sv
// Host write port of the scan controller: double-buffered hex word handshake.
interface svn_scan_ctrl_if #(
    parameter int unsigned N_DIG = 8
);
    logic                 wr_en;
    logic [4*N_DIG-1:0]   wr_data;
    logic [N_DIG-1:0]     wr_dp;
    logic [N_DIG-1:0]     wr_den;
    logic                 wr_ready;

    modport master (output wr_en, output wr_data, output wr_dp, output wr_den, input wr_ready);
    modport slave  (input wr_en, input wr_data, input wr_dp, input wr_den, output wr_ready);
endinterface

// File: rtl/svn_scan_ctrl_tick_gen.sv
// Slot prescaler: counts 0..DIV-1, flags slot end, the cycle before it, and blank end.
module scan_tick_gen #(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned BLANK = 16
) (
    input  logic clk,
    input  logic sys_rst,
    output logic tick_o,
    output logic tick_next_o,
    output logic blank_end_o
);
    localparam int unsigned CW         = $clog2(DIV);
    localparam int unsigned BLANK_LAST = (BLANK == 0) ? 0 : BLANK - 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o      = (cnt_q == CW'(DIV - 1));
    assign tick_next_o = (cnt_q == CW'(DIV - 2));
    assign blank_end_o = (BLANK == 0) ? 1'b1 : (cnt_q == CW'(BLANK_LAST));

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (sys_rst) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/svn_scan_ctrl.sv
// Rate-controlled 7-segment scan: double-buffered digits, dead-time blank, registered anodes.
module svn_scan_ctrl
    import svn_pkg::*;
#(
    parameter int unsigned N_DIG = 8,
    parameter int unsigned DIV   = 100000,
    parameter int unsigned BLANK = 16
) (
    input  logic                                clk,
    input  logic                                sys_rst,
    svn_scan_ctrl_if.slave                      wr,
    output logic [3:0]                          seg_val,
    output logic                                seg_dp,
    output logic [N_DIG-1:0]                    AN,
    output logic [svn_pkg::idx_width(N_DIG)-1:0] digit_idx,
    output logic                                frame_done
);
    localparam int unsigned IW = idx_width(N_DIG);
    localparam logic [N_DIG-1:0] AN_ALL = AN_OFF[N_DIG-1:0];
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

    logic tick, tick_next, blank_end;

    scan_tick_gen #(.DIV(DIV), .BLANK(BLANK)) u_tick (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .tick_o      (tick),
        .tick_next_o (tick_next),
        .blank_end_o (blank_end)
    );

    scan_state_t          state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [4*N_DIG-1:0]   act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [N_DIG-1:0]     act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic [N_DIG-1:0]     act_den_q, act_den_d, pend_den_q, pend_den_d;
    logic                 pend_v_q, pend_v_d;
    logic [3:0]           seg_val_q, seg_val_d;
    logic                 seg_dp_q, seg_dp_d;
    logic [N_DIG-1:0]     an_q, an_d;
    logic                 fd_q, fd_d;
    logic                 commit;

    assign wr.wr_ready = ~pend_v_q;

    // Next-state: slot stepping, frame-boundary commit, write capture, anode drive.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_den_d   = act_den_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_den_d  = pend_den_q;
        pend_v_d    = pend_v_q;
        seg_val_d   = seg_val_q;
        seg_dp_d    = seg_dp_q;
        an_d        = AN_ALL;
        fd_d        = tick_next && (idx_q == IDX_LAST);
        commit      = tick && (idx_q == IDX_LAST) && pend_v_q;

        if (commit) begin
            act_data_d = pend_data_q;
            act_dp_d   = pend_dp_q;
            act_den_d  = pend_den_q;
            pend_v_d   = 1'b0;
        end
        // A pending word blocks writes, so this never coincides with a commit.
        if (wr.wr_en && !pend_v_q) begin
            pend_data_d = wr.wr_data;
            pend_dp_d   = wr.wr_dp;
            pend_den_d  = wr.wr_den;
            pend_v_d    = 1'b1;
        end

        case (state_q)
            ST_BLANK: if (blank_end) state_d = ST_SHOW;
            ST_SHOW:  if (tick) state_d = (BLANK == 0) ? ST_SHOW : ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase

        if (tick) begin
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            seg_val_d = act_data_d[{idx_d, 2'b00} +: 4];
            seg_dp_d  = act_dp_d[idx_d];
        end

        // Anodes follow next-cycle state/index, so at most one is ever low.
        if (state_d == ST_SHOW) an_d[idx_d] = ~act_den_d[idx_d];
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q     <= ST_BLANK;
            idx_q       <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_den_q   <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_den_q  <= '0;
            pend_v_q    <= 1'b0;
            seg_val_q   <= '0;
            seg_dp_q    <= 1'b0;
            an_q        <= AN_ALL;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_den_q   <= act_den_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_den_q  <= pend_den_d;
            pend_v_q    <= pend_v_d;
            seg_val_q   <= seg_val_d;
            seg_dp_q    <= seg_dp_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

    assign seg_val    = seg_val_q;
    assign seg_dp     = seg_dp_q;
    assign AN         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = fd_q;
endmodule
